// File: rtl/kbd_pkg.sv
// Shared constants, FSM state encoding and key indexing for the 5x6 key-matrix scanner.
// Combinational helpers only; no latency and no backpressure.
package kbd_pkg;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 6;
    localparam int NUM_KEYS = 30;
    localparam int KEY_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_UPDATE,
        ST_NEXT
    } scan_state_t;

    typedef struct packed {
        logic [KEY_W-1:0] code;
        logic             press;
    } evt_t;

    function automatic logic [KEY_W-1:0] key_index(input logic [2:0] row, input logic [2:0] col);
        return KEY_W'(int'(row) * NUM_COLS + int'(col));
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Show-ahead FIFO for key events; a push shows at the head one cycle later.
// Backpressure: pop_rdy low holds the head, and a push into a full FIFO is kept only if a pop happens that cycle.
module kbd_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_drop,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          vld_q;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = vld_q && pop_rdy;
    assign push_ok   = push_vld && (!full || pop);
    assign push_drop = push_vld && !push_ok;
    assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            vld_q <= (count_nxt != '0);
        end
    end

    assign pop_vld = vld_q;
    assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/kbd_scanner.sv
// Row-scan sequencer with per-key debounce, publishing key levels and a press/release event queue.
// Row period SETTLE_CYCLES+8; an event shows one cycle after its UPDATE cycle; events are dropped (evt_ovf) when the queue is full and not popped.
module kbd_scanner
    import kbd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int EVT_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    output logic [NUM_ROWS-1:0] KBD_row,
    input  logic [NUM_COLS-1:0] KBD_col,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_code,
    output logic                evt_press,
    output logic                evt_ovf
);

    localparam int SW = $clog2(SETTLE_CYCLES);

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [2:0]          row;
    logic [2:0]          row_nxt;
    logic [2:0]          col;
    logic [SW-1:0]       settle_cnt;
    logic [NUM_COLS-1:0] col_s1;
    logic [NUM_COLS-1:0] col_s2;
    logic [NUM_COLS-1:0] col_raw;
    logic [NUM_KEYS-1:0] key_q;
    logic [2:0]          cnt [NUM_KEYS];
    logic [NUM_ROWS-1:0] row_q;
    logic [NUM_ROWS-1:0] row_strobe_nxt;
    logic                ovf_q;

    logic [KEY_W-1:0]    cur_key;
    logic                cur_raw;
    logic                disagree;
    logic                flip;
    evt_t                push_evt;
    evt_t                head_evt;
    logic                push_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (scan_en) state_nxt = ST_DRIVE;
            ST_DRIVE:  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = ST_UPDATE;
            ST_UPDATE: if (col == 3'(NUM_COLS - 1)) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = scan_en ? ST_DRIVE : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Parking resets the row so a restart always begins a fresh scan at row 0.
    always_comb begin
        row_nxt = row;
        if (state == ST_NEXT) begin
            row_nxt = (!scan_en || row == 3'(NUM_ROWS - 1)) ? 3'd0 : row + 3'd1;
        end
        row_strobe_nxt = '1;
        if (state_nxt == ST_DRIVE || state_nxt == ST_SAMPLE) begin
            row_strobe_nxt = ~(NUM_ROWS'(1) << row_nxt);
        end
    end

    assign cur_key  = key_index(row, col);
    assign cur_raw  = col_raw[col];
    assign disagree = (state == ST_UPDATE) && (cur_raw != key_q[cur_key]);
    assign flip     = disagree && (cnt[cur_key] == 3'(DEBOUNCE_SCANS - 1));
    assign push_evt = '{code: cur_key, press: ~key_q[cur_key]};

    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            col        <= '0;
            settle_cnt <= '0;
            col_s1     <= '1;
            col_s2     <= '1;
            col_raw    <= '0;
            key_q      <= '0;
            row_q      <= '1;
            ovf_q      <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            col_s1     <= KBD_col;
            col_s2     <= col_s1;
            row        <= row_nxt;
            row_q      <= row_strobe_nxt;
            settle_cnt <= (state == ST_DRIVE) ? settle_cnt + SW'(1) : '0;
            col        <= (state == ST_UPDATE) ? col + 3'd1 : 3'd0;
            if (state == ST_SAMPLE) begin
                col_raw <= ~col_s2;
            end
            if (disagree) begin
                if (flip) begin
                    key_q[cur_key] <= ~key_q[cur_key];
                    cnt[cur_key]   <= '0;
                end else begin
                    cnt[cur_key] <= cnt[cur_key] + 3'd1;
                end
            end else if (state == ST_UPDATE) begin
                cnt[cur_key] <= '0;
            end
            if (push_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    kbd_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .W     ($bits(evt_t))
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (flip),
        .push_dat  (push_evt),
        .push_drop (push_drop),
        .pop_vld   (evt_valid),
        .pop_rdy   (evt_ready),
        .pop_dat   (head_evt)
    );

    assign KBD_row   = row_q;
    assign key_state = key_q;
    assign evt_code  = head_evt.code;
    assign evt_press = head_evt.press;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_kbd_scanner.sv
// Bench for kbd_scanner: a virtual key matrix driven from a pressed-key vector, with a per-scan
// debounce and event-queue model compared against key_state and the popped event stream.
module tb_kbd_scanner;
    import kbd_pkg::*;

    localparam int SETTLE = 64;
    localparam int DB     = 4;
    localparam int DEPTH  = 4;
    localparam int ROWP   = SETTLE + 8;
    localparam int SCAN   = 5 * ROWP;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic [4:0]  KBD_row;
    logic [5:0]  KBD_col;
    logic [29:0] key_state;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_code;
    logic        evt_press;
    logic        evt_ovf;

    logic [29:0] pressed;
    int          total = 0;
    int          bad   = 0;
    logic [5:0]  got[$];
    logic [5:0]  mfifo[$];
    logic [5:0]  last_evts[$];
    logic [29:0] mks;
    int          mcnt [30];
    logic        movf;

    always #5 clk = ~clk;

    kbd_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (DB),
        .EVT_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .KBD_row   (KBD_row),
        .KBD_col   (KBD_col),
        .key_state (key_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_press (evt_press),
        .evt_ovf   (evt_ovf)
    );

    always_comb begin
        KBD_col = '1;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (KBD_row[r] == 1'b0 && pressed[r*6+c]) KBD_col[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1)
            got.push_back({evt_code, evt_press});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_row(input logic [4:0] target, output int n);
        logic [4:0] prev;
        bit         hit;
        n    = 0;
        hit  = 0;
        prev = KBD_row;
        while (!hit && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            chk("row_onehot", 32'($countones(~KBD_row) <= 1), 1);
            hit  = (prev != target) && (KBD_row == target);
            prev = KBD_row;
        end
        chk("row_wait_hit", 32'(hit), 1);
    endtask

    function automatic void mpush(input logic [5:0] e);
        if (evt_ready) mfifo.push_back(e);
        else if (mfifo.size() < DEPTH) mfifo.push_back(e);
        else movf = 1'b1;
    endfunction

    // Debounce rule applied once per full scan, keys visited in row-then-column order.
    function automatic void model_scan(input logic [29:0] p);
        for (int k = 0; k < 30; k++) begin
            if (p[k] == mks[k]) mcnt[k] = 0;
            else begin
                mcnt[k]++;
                if (mcnt[k] == DB) begin
                    mks[k]  = p[k];
                    mcnt[k] = 0;
                    mpush({5'(k), p[k]});
                end
            end
        end
    endfunction

    task automatic check_drain();
        chk("evt_count", got.size(), mfifo.size());
        for (int i = 0; i < got.size() && i < mfifo.size(); i++)
            chk("evt_data", 32'(got[i]), 32'(mfifo[i]));
        last_evts = got;
        got.delete();
        mfifo.delete();
    endtask

    task automatic do_scan(input logic [29:0] p);
        int n;
        pressed = p;
        wait_row(5'b11110, n);
        chk("scan_period", n, SCAN);
        model_scan(p);
        chk("key_state", key_state, mks);
        chk("evt_ovf", 32'(evt_ovf), 32'(movf));
        if (evt_ready) check_drain();
        else begin
            chk("held_no_pop", got.size(), 0);
            last_evts.delete();
        end
    endtask

    task automatic model_reset();
        mks  = '0;
        movf = 1'b0;
        for (int k = 0; k < 30; k++) mcnt[k] = 0;
        mfifo.delete();
        got.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          h;
        logic [29:0] p;

        rst       = 1'b1;
        scan_en   = 1'b1;
        evt_ready = 1'b1;
        pressed   = '0;
        model_reset();
        cyc(3);
        chk("rst_row", KBD_row, 5'h1F);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_keys", key_state, 0);
        chk("rst_ovf", 32'(evt_ovf), 0);
        chk("rst_code", evt_code, 0);
        chk("rst_press", 32'(evt_press), 0);
        rst = 1'b0;

        wait_row(5'b11110, n);
        chk("first_drive", n, 1);
        wait_row(5'b11101, n); chk("row_period1", n, ROWP);
        wait_row(5'b11011, n); chk("row_period2", n, ROWP);
        wait_row(5'b10111, n); chk("row_period3", n, ROWP);
        wait_row(5'b01111, n); chk("row_period4", n, ROWP);
        wait_row(5'b11110, n); chk("row_period0", n, ROWP);

        // clean press of key 15 (row 2, col 3)
        repeat (3) do_scan(30'(1) << 15);
        chk("press_early", 32'(key_state[15]), 0);
        do_scan(30'(1) << 15);
        chk("press_level", 32'(key_state[15]), 1);
        chk("press_nevt", last_evts.size(), 1);
        chk("press_evt", 32'(last_evts[0]), 32'h1F);

        repeat (3) do_scan('0);
        chk("release_early", 32'(key_state[15]), 1);
        do_scan('0);
        chk("release_level", 32'(key_state[15]), 0);
        chk("release_nevt", last_evts.size(), 1);
        chk("release_evt", 32'(last_evts[0]), 32'h1E);

        // bounce: three low scans then high, twice; the count must restart
        repeat (3) do_scan(30'(1) << 15);
        do_scan('0);
        chk("bounce_level", 32'(key_state[15]), 0);
        repeat (3) do_scan(30'(1) << 15);
        chk("bounce_reset", 32'(key_state[15]), 0);
        do_scan('0);

        for (int i = 0; i < 8; i++) begin
            p = $urandom & $urandom & 30'h3FFFFFFF;
            h = $urandom_range(1, 6);
            repeat (h) do_scan(p);
        end
        repeat (4) do_scan('0);
        chk("clear_keys", key_state, 0);
        chk("pre_ovf", 32'(evt_ovf), 0);

        // overflow: five simultaneous presses into a four-deep queue
        evt_ready = 1'b0;
        p = '0;
        while ($countones(p) < 5) p[$urandom_range(0, 29)] = 1'b1;
        repeat (4) do_scan(p);
        chk("ovf_valid", 32'(evt_valid), 1);
        chk("ovf_flag", 32'(evt_ovf), 1);
        chk("ovf_keys", key_state, p);
        chk("ovf_head", 32'({evt_code, evt_press}), 32'(mfifo[0]));
        evt_ready = 1'b1;
        cyc(10);
        chk("ovf_pop_count", got.size(), 4);
        check_drain();
        chk("ovf_empty", 32'(evt_valid), 0);
        wait_row(5'b11110, n);

        // park mid-DRIVE of row 1
        wait_row(5'b11101, n);
        chk("park_row1_start", n, ROWP);
        cyc(20);
        scan_en = 1'b0;
        cyc(44);
        chk("park_row1_held", KBD_row, 5'b11101);
        cyc(1);
        chk("park_row_off", KBD_row, 5'h1F);
        cyc(200);
        chk("park_idle", KBD_row, 5'h1F);
        chk("park_keys", key_state, mks);
        chk("park_valid", 32'(evt_valid), 0);
        scan_en = 1'b1;
        wait_row(5'b11110, n);
        chk("resume_wait", n, 1);

        // fill the queue, then reset during UPDATE
        evt_ready = 1'b0;
        repeat (4) do_scan('0);
        repeat (4) do_scan(30'(1) << 15);
        chk("pre_rst_key", 32'(key_state[15]), 1);
        cyc(65);
        chk("in_update", KBD_row, 5'h1F);
        chk("pre_rst_valid", 32'(evt_valid), 1);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_valid", 32'(evt_valid), 0);
        chk("mid_rst_keys", key_state, 0);
        chk("mid_rst_ovf", 32'(evt_ovf), 0);
        chk("mid_rst_row", KBD_row, 5'h1F);
        rst       = 1'b0;
        evt_ready = 1'b1;
        model_reset();
        wait_row(5'b11110, n);
        chk("post_rst_drive", n, 1);

        repeat (4) do_scan(30'(1));
        chk("post_rst_nevt", last_evts.size(), 1);
        chk("post_rst_evt", 32'(last_evts[0]), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
